reaction_timer_core: RTL and testbench
======================================

Name: reaction_timer_core

Overview:
Timing engine behind the Timer AXI4-Lite register slave. It consumes the slave's decoded command strobes and timeout register, and it produces the count, capture and status values that the slave returns on reads. It measures reaction time: it counts ticks from a start command until a stop command, an external button edge, or a timeout. It sits between the register slave and the board button/interrupt pins.

Parameters:
CLK_FREQ_HZ, 100_000_000, input clock frequency.
TICK_HZ, 1000, count resolution (1 ms). DIV = CLK_FREQ_HZ/TICK_HZ; must divide exactly and DIV >= 2.
CNT_W, 32, width of count, capture and timeout.

Ports:
s00_axi_aclk  in  1  sole clock.
s00_axi_aresetn  in  1  asynchronous active-low reset.
cmd_start  in  1  one-cycle strobe: CTRL write with bit0=1.
cmd_stop  in  1  one-cycle strobe: CTRL write with bit1=1.
cmd_clear  in  1  one-cycle strobe: CTRL write with bit2=1.
timeout_val  in  CNT_W  timeout register; 0 disables timeout.
btn_i  in  1  asynchronous reaction button, active-high.
count_o  out  CNT_W  live tick count.
capture_o  out  CNT_W  count latched at stop.
running_o  out  1  high in RUN.
done_o  out  1  high in HALT.
timeout_o  out  1  high in TIMEOUT.
irq_o  out  1  one-cycle pulse on entering HALT or TIMEOUT.

Behaviour:
- Reset (async assert, sync release): state IDLE; presc, count_o, capture_o, sync regs = 0; all flags and irq_o = 0.
- Button path: 2-FF synchroniser plus a delay reg. btn_ev = sync2 & ~dly. btn_i first sampled high at edge k causes the FSM to act at edge k+2. Button events outside RUN are discarded.
- Prescaler: runs only in RUN. Counts 0..DIV-1; tick = (presc==DIV-1), then wraps to 0. Cleared on entry to RUN.
- stop_ev = cmd_stop | btn_ev.
- State IDLE:
  - cmd_start -> RUN; count=0, presc=0.
  - All other inputs ignored.
- State RUN:
  - On tick, count increments; count saturates at all-ones.
  - stop_ev -> HALT; capture_o = current count (pre-increment even if tick in same cycle); irq_o pulse.
  - tick with timeout_val!=0 and count+1==timeout_val, and no stop_ev -> TIMEOUT; count = timeout_val; capture_o = timeout_val; irq_o pulse.
  - cmd_start ignored.
- State HALT or TIMEOUT:
  - count frozen.
  - cmd_start -> RUN; count=0, presc=0; capture_o retained until next capture.
  - stop_ev ignored.
- Priority, same cycle: cmd_clear > stop_ev > timeout > cmd_start.
- cmd_clear, any state -> IDLE; count, capture, presc = 0; no irq_o.
- timeout_val changes take effect at the next tick compare. If timeout_val <= count while RUN, no timeout fires until count saturates; count then holds at all-ones and never matches.
- Outputs are registered; the flags are decoded from the state register. Latency from a strobe to an output change is 1 cycle.
- Reset asserted mid-operation returns all outputs to reset values immediately; no irq_o.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, HALT, TIMEOUT}.
  - CTRL bit indices START=0, STOP=1, CLEAR=2.
  - Register offsets CTRL=0x0, TIMEOUT=0x4, COUNT=0x8, CAPTURE=0xC.
- Sub-module btn_sync_edge: synchroniser plus rising-edge detect, parameter-free. Outputs btn_ev.

Test Plan (CLK_FREQ_HZ=100, TICK_HZ=10 -> DIV=10; CNT_W=32):
- Release reset, idle 20 cycles, btn_i pulses -> count_o=0, capture_o=0, all flags 0, irq_o never high.
- cmd_start, wait 35 cycles, cmd_stop -> capture_o=3, done_o=1, running_o=0, irq_o high exactly 1 cycle; count frozen at 3 for 50 further cycles.
- timeout_val=5, cmd_start -> at cycle 50 after start: timeout_o=1, count_o=5, capture_o=5, one irq_o pulse; a later cmd_stop has no effect.
- In RUN, btn_i rises asynchronously -> done_o asserts on the 3rd edge after first sampling; capture_o equals count at that edge. A second btn_i pulse while in HALT is ignored.
- Same-cycle cases:
  - cmd_stop coincident with the tick taking count 6->7 -> capture_o=6.
  - cmd_stop and timeout tick together -> HALT, timeout_o=0.
  - cmd_clear and cmd_stop together -> IDLE, all zero, no irq_o.
- Assert s00_axi_aresetn low mid-RUN with count=4, off the clock edge -> all outputs 0 before the next edge. After release, cmd_start counts from 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the reaction timer.
// Register map values mirror the AXI4-Lite slave's decode.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALT    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_CLEAR = 2;

    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_TIMEOUT = 4'h4;
    localparam logic [3:0] REG_COUNT   = 4'h8;
    localparam logic [3:0] REG_CAPTURE = 4'hC;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the async button plus rising-edge detect.
// btn_ev_o is a one-cycle pulse two edges after btn_i is first sampled high.
module btn_sync_edge
    import timer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_ev_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q, dly_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign btn_ev_o = sync2_q & ~dly_q;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time engine: counts prescaled ticks from start until
// stop, button edge or timeout, and reports count/capture/status.
module reaction_timer_core
    import timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int CNT_W       = 32
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_aresetn,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cmd_clear,
    input  logic [CNT_W-1:0] timeout_val,
    input  logic             btn_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] capture_o,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             irq_o
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    generate
        if ((CLK_FREQ_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
            $error("CLK_FREQ_HZ/TICK_HZ must divide exactly and be >= 2");
        end
    endgenerate

    logic clk, rst_n;
    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    logic btn_ev;

    btn_sync_edge u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_i    (btn_i),
        .btn_ev_o (btn_ev)
    );

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] capture_q, capture_d;
    logic             irq_q, irq_d;

    logic             tick;
    logic             stop_ev;
    logic [CNT_W-1:0] count_inc;
    logic             to_hit;

    assign tick      = (presc_q == PRESC_MAX);
    assign stop_ev   = cmd_stop | btn_ev;
    assign count_inc = count_q + 1'b1;
    // count_inc wraps to 0 at saturation, so a non-zero timeout can't match
    assign to_hit    = (timeout_val != '0) && (count_inc == timeout_val);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        capture_d = capture_q;
        irq_d     = 1'b0;
        if (cmd_clear) begin
            state_d   = IDLE;
            presc_d   = '0;
            count_d   = '0;
            capture_d = '0;
        end else begin
            unique case (state_q)
                IDLE, HALT, TIMEOUT: begin
                    if (cmd_start) begin
                        state_d = RUN;
                        presc_d = '0;
                        count_d = '0;
                    end
                end
                RUN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (stop_ev) begin
                        state_d   = HALT;
                        capture_d = count_q;
                        irq_d     = 1'b1;
                    end else if (tick) begin
                        if (to_hit) begin
                            state_d   = TIMEOUT;
                            count_d   = timeout_val;
                            capture_d = timeout_val;
                            irq_d     = 1'b1;
                        end else if (count_q != CNT_MAX) begin
                            count_d = count_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            capture_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            capture_q <= capture_d;
            irq_q     <= irq_d;
        end
    end

    assign count_o   = count_q;
    assign capture_o = capture_q;
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == HALT);
    assign timeout_o = (state_q == TIMEOUT);
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: directed scenarios plus random
// stimulus, all checked every cycle against an elapsed-time model.
module tb_reaction_timer_core;

    localparam int DIV = 10;
    localparam int W   = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         clr = 1'b0;
    logic         btn = 1'b0;
    logic [W-1:0] tv = '0;

    logic [W-1:0] count_o, capture_o;
    logic         running_o, done_o, timeout_o, irq_o;

    reaction_timer_core #(
        .CLK_FREQ_HZ (100),
        .TICK_HZ     (10),
        .CNT_W       (W)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .cmd_start       (start),
        .cmd_stop        (stop),
        .cmd_clear       (clr),
        .timeout_val     (tv),
        .btn_i           (btn),
        .count_o         (count_o),
        .capture_o       (capture_o),
        .running_o       (running_o),
        .done_o          (done_o),
        .timeout_o       (timeout_o),
        .irq_o           (irq_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int irq_cnt = 0;

    // model: 0 idle, 1 run, 2 halt, 3 timeout
    int           m_st;
    longint       m_el;
    logic [W-1:0] m_cnt, m_cap;
    logic         m_irq;
    logic [2:0]   bh;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_st  = 0;
        m_el  = 0;
        m_cnt = '0;
        m_cap = '0;
        m_irq = 1'b0;
        bh    = '0;
    endtask

    // Called at each rising edge with the inputs that edge sees.
    task automatic step();
        logic   ev, stp;
        longint q;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ev    = bh[1] & ~bh[2];
        bh    = {bh[1:0], btn};
        stp   = stop | ev;
        m_irq = 1'b0;
        if (clr) begin
            m_st  = 0;
            m_el  = 0;
            m_cnt = '0;
            m_cap = '0;
        end else if (m_st == 1) begin
            m_el++;
            q = m_el / DIV;
            if (stp) begin
                m_st  = 2;
                m_cap = m_cnt;
                m_irq = 1'b1;
            end else if (m_el % DIV == 0) begin
                if (tv != 0 && q == longint'({32'h0, tv})) begin
                    m_st  = 3;
                    m_cnt = tv;
                    m_cap = tv;
                    m_irq = 1'b1;
                end else begin
                    m_cnt = (q > 64'hFFFF_FFFF) ? '1 : q[W-1:0];
                end
            end
        end else if (start) begin
            m_st  = 1;
            m_el  = 0;
            m_cnt = '0;
        end
    endtask

    task automatic check_all();
        if (irq_o) irq_cnt++;
        chk("count", count_o, m_cnt);
        chk("capture", capture_o, m_cap);
        chk("running", running_o, m_st == 1);
        chk("done", done_o, m_st == 2);
        chk("timeout", timeout_o, m_st == 3);
        chk("irq", irq_o, m_irq);
    endtask

    task automatic cyc();
        @(posedge clk);
        step();
        @(negedge clk);
        check_all();
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    int base;

    initial begin
        m_reset();
        repeat (3) cyc();
        chk("rst_count", count_o, 0);
        rst_n = 1'b1;

        // idle with button activity: nothing happens
        for (int i = 0; i < 20; i++) begin
            btn = (i % 6) < 3;
            cyc();
        end
        btn = 1'b0;
        repeat (4) cyc();
        chk("idle_irq", irq_cnt, 0);
        chk("idle_cap", capture_o, 0);

        // plain start/stop
        base = irq_cnt;
        go();
        repeat (34) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_cap", capture_o, 3);
        chk("stop_done", done_o, 1);
        repeat (50) cyc();
        chk("halt_cnt", count_o, 3);
        chk("stop_irqs", irq_cnt - base, 1);

        // timeout at 5 ticks
        tv   = 5;
        base = irq_cnt;
        go();
        repeat (49) cyc();
        chk("pre_to", timeout_o, 0);
        cyc();
        chk("to_flag", timeout_o, 1);
        chk("to_cnt", count_o, 5);
        chk("to_cap", capture_o, 5);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (5) cyc();
        chk("to_sticky", timeout_o, 1);
        chk("to_irqs", irq_cnt - base, 1);

        // button edge in RUN, driven between clock edges
        tv = 0;
        go();
        repeat (23) cyc();
        #2 btn = 1'b1;
        cyc();
        cyc();
        chk("btn_k1", done_o, 0);
        cyc();
        chk("btn_k2", done_o, 1);
        chk("btn_cap", capture_o, 2);
        btn = 1'b0;
        repeat (4) cyc();
        btn = 1'b1;
        repeat (3) cyc();
        btn = 1'b0;
        repeat (5) cyc();
        chk("btn_2nd", capture_o, 2);
        chk("btn_2nd_d", done_o, 1);

        // stop on the tick that would take 6 -> 7
        go();
        repeat (69) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("tick_stop", capture_o, 6);

        // stop beats timeout
        tv = 5;
        go();
        repeat (49) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("st_to_d", done_o, 1);
        chk("st_to_t", timeout_o, 0);
        chk("st_to_c", capture_o, 4);

        // clear beats stop
        tv = 0;
        go();
        repeat (15) cyc();
        base = irq_cnt;
        clr  = 1'b1;
        stop = 1'b1;
        cyc();
        clr  = 1'b0;
        stop = 1'b0;
        cyc();
        chk("clr_run", running_o, 0);
        chk("clr_cnt", count_o, 0);
        chk("clr_irq", irq_cnt - base, 0);

        // async reset mid-run
        go();
        repeat (45) cyc();
        chk("pre_rst", count_o, 4);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        repeat (2) cyc();
        rst_n = 1'b1;
        go();
        chk("rst_go", count_o, 0);
        repeat (10) cyc();
        chk("rst_cnt", count_o, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 100) < 4;
            stop  = ($urandom % 100) < 2;
            clr   = ($urandom % 300) < 1;
            if ($urandom % 40 == 0) btn = ~btn;
            if ($urandom % 120 == 0) tv = $urandom % 10;
            cyc();
        end
        start = 1'b0;
        stop  = 1'b0;
        clr   = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
